// File: rtl/mem_arbiter.sv
// =============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter and sequencer sharing one data-RAM port
//               between instruction fetch (port 0, read-only) and the
//               load/store unit (port 1, read/write). Each transaction runs
//               IDLE -> ACCESS -> RESP with valid/ready handshakes on both
//               the request and response sides.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDRESS_LENGTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,

  // Port 0: instruction fetch (read-only)
  input  logic                      req0_valid,
  input  logic [ADDRESS_LENGTH-1:0] req0_addr,
  output logic                      req0_ready,
  output logic                      rsp0_valid,
  input  logic                      rsp0_ready,
  output logic [ADDRESS_LENGTH-1:0] rsp0_data,

  // Port 1: load/store unit
  input  logic                      req1_valid,
  input  logic                      req1_we,
  input  logic [1:0]                req1_size,
  input  logic [ADDRESS_LENGTH-1:0] req1_addr,
  input  logic [ADDRESS_LENGTH-1:0] req1_wdata,
  output logic                      req1_ready,
  output logic                      rsp1_valid,
  input  logic                      rsp1_ready,
  output logic [ADDRESS_LENGTH-1:0] rsp1_data,

  // Data RAM port
  output logic [ADDRESS_LENGTH-1:0] mem_a,
  output logic [ADDRESS_LENGTH-1:0] mem_wd,
  output logic                      mem_sb,
  output logic                      mem_sh,
  output logic                      mem_sw,
  input  logic [ADDRESS_LENGTH-1:0] mem_rd
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                    state_q;
  logic                      last_q;     // last granted port; 1 after reset so port 0 wins first tie
  logic                      port_q;     // port owning the in-flight transaction
  logic                      we_q;       // in-flight transaction is a port 1 store
  logic [ADDRESS_LENGTH-1:0] mem_a_q;
  logic [ADDRESS_LENGTH-1:0] mem_wd_q;
  logic                      sb_q;
  logic                      sh_q;
  logic                      sw_q;
  logic                      rsp0_valid_q;
  logic                      rsp1_valid_q;
  logic [ADDRESS_LENGTH-1:0] rsp0_data_q;
  logic [ADDRESS_LENGTH-1:0] rsp1_data_q;

  logic                      grant_d;    // port that would be granted this cycle
  logic                      idle;
  logic                      accept;
  logic                      store_d;
  logic                      sb_d;
  logic                      sh_d;
  logic                      sw_d;

  // Round-robin pick: a lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    grant_d = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_d = ~last_q;
    end else if (req1_valid) begin
      grant_d = 1'b1;
    end
  end

  assign idle       = (state_q == ST_IDLE);
  assign req0_ready = idle && !grant_d && req0_valid && !rst;
  assign req1_ready = idle &&  grant_d && req1_valid && !rst;
  assign accept     = req0_ready || req1_ready;

  // Strobe selection for a store being accepted; size 1x means a full word.
  assign store_d = grant_d && req1_we;
  assign sb_d    = store_d && (req1_size == 2'b00);
  assign sh_d    = store_d && (req1_size == 2'b01);
  assign sw_d    = store_d && req1_size[1];

  // Transaction sequencer: latches the request, drives the RAM for one cycle,
  // then holds the response until the owning port consumes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_q       <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      mem_a_q      <= '0;
      mem_wd_q     <= '0;
      sb_q         <= 1'b0;
      sh_q         <= 1'b0;
      sw_q         <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            mem_a_q  <= grant_d ? req1_addr : req0_addr;
            mem_wd_q <= store_d ? req1_wdata : '0;
            we_q     <= store_d;
            port_q   <= grant_d;
            last_q   <= grant_d;
            sb_q     <= sb_d;
            sh_q     <= sh_d;
            sw_q     <= sw_d;
            state_q  <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          // The RAM commits any store on this edge; strobes are single-cycle.
          sb_q <= 1'b0;
          sh_q <= 1'b0;
          sw_q <= 1'b0;
          if (!port_q) begin
            rsp0_data_q  <= mem_rd;
            rsp0_valid_q <= 1'b1;
          end else begin
            rsp1_data_q  <= we_q ? '0 : mem_rd;
            rsp1_valid_q <= 1'b1;
          end
          state_q <= ST_RESP;
        end

        ST_RESP: begin
          if (!port_q) begin
            if (rsp0_ready) begin
              rsp0_valid_q <= 1'b0;
              state_q      <= ST_IDLE;
            end
          end else begin
            if (rsp1_ready) begin
              rsp1_valid_q <= 1'b0;
              state_q      <= ST_IDLE;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_a      = mem_a_q;
  assign mem_wd     = mem_wd_q;
  assign mem_sb     = sb_q;
  assign mem_sh     = sh_q;
  assign mem_sw     = sw_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// =============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a small
//               byte-addressed RAM model (word-aligned combinational read).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic          req0_ready;
  logic          rsp0_valid;
  logic          rsp0_ready = 1'b1;
  logic [AW-1:0] rsp0_data;
  logic          req1_valid = 1'b0;
  logic          req1_we = 1'b0;
  logic [1:0]    req1_size = 2'b00;
  logic [AW-1:0] req1_addr = '0;
  logic [AW-1:0] req1_wdata = '0;
  logic          req1_ready;
  logic          rsp1_valid;
  logic          rsp1_ready = 1'b1;
  logic [AW-1:0] rsp1_data;
  logic [AW-1:0] mem_a;
  logic [AW-1:0] mem_wd;
  logic          mem_sb;
  logic          mem_sh;
  logic          mem_sw;
  logic [AW-1:0] mem_rd;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ram [0:255];

  mem_arbiter #(.ADDRESS_LENGTH(AW)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .req1_valid (req1_valid),
    .req1_we    (req1_we),
    .req1_size  (req1_size),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_sb     (mem_sb),
    .mem_sh     (mem_sh),
    .mem_sw     (mem_sw),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  // RAM model: word index from address bits [9:2], lane writes on strobes.
  assign mem_rd = ram[mem_a[9:2]];

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[0] = 32'hCAFEF00D;   // 0x10000
    ram[1] = 32'h11223344;   // 0x10004
    ram[2] = 32'h00000000;   // 0x10008
    ram[3] = 32'h0BADC0DE;   // 0x1000C
    forever begin
      @(posedge clk);
      if (mem_sw) begin
        ram[mem_a[9:2]] <= mem_wd;
      end else if (mem_sh) begin
        if (mem_a[1]) ram[mem_a[9:2]][31:16] <= mem_wd[15:0];
        else          ram[mem_a[9:2]][15:0]  <= mem_wd[15:0];
      end else if (mem_sb) begin
        case (mem_a[1:0])
          2'd0:    ram[mem_a[9:2]][7:0]   <= mem_wd[7:0];
          2'd1:    ram[mem_a[9:2]][15:8]  <= mem_wd[7:0];
          2'd2:    ram[mem_a[9:2]][23:16] <= mem_wd[7:0];
          default: ram[mem_a[9:2]][31:24] <= mem_wd[7:0];
        endcase
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete transaction on one port with rsp_ready held high.
  task automatic run_txn(input bit port, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] exp_strb, input logic [31:0] exp_data,
                         input string tag);
    int waited;
    bit rdy;
    @(negedge clk);
    if (!port) begin
      req0_valid = 1'b1; req0_addr = addr;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_size = size;
      req1_addr = addr; req1_wdata = wdata;
    end
    #1;
    rdy = port ? req1_ready : req0_ready;
    waited = 0;
    while (!rdy && waited < 8) begin
      @(negedge clk); #1;
      rdy = port ? req1_ready : req0_ready;
      waited++;
    end
    check_eq({tag, "_ready"}, {31'd0, rdy}, 32'd1);
    if (!rdy) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check_eq({tag, "_mem_a"}, mem_a, addr);
    check_eq({tag, "_strb"}, {29'd0, mem_sw, mem_sh, mem_sb}, {29'd0, exp_strb});
    check_eq({tag, "_mem_wd"}, mem_wd, (port && we) ? wdata : 32'd0);
    @(negedge clk); #1;
    check_eq({tag, "_rsp_valid"}, {31'd0, port ? rsp1_valid : rsp0_valid}, 32'd1);
    check_eq({tag, "_rsp_data"}, port ? rsp1_data : rsp0_data, exp_data);
    @(negedge clk); #1;
    check_eq({tag, "_rsp_clear"}, {31'd0, port ? rsp1_valid : rsp0_valid}, 32'd0);
  endtask

  // Stimulus sequence
  initial begin
    int exp_p;

    // ---- reset state (ready must stay low while rst is high) ----
    @(negedge clk); @(negedge clk);
    req0_valid = 1'b1; req0_addr = 32'h10004;
    #1;
    check_eq("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check_eq("rst_mem_a", mem_a, 32'd0);
    check_eq("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check_eq("rst_strb", {29'd0, mem_sw, mem_sh, mem_sb}, 32'd0);
    req0_valid = 1'b0;
    rst = 1'b0;

    // ---- reset in the middle of a word store ----
    @(negedge clk);
    req1_valid = 1'b1; req1_we = 1'b1; req1_size = 2'b10;
    req1_addr = 32'h10000; req1_wdata = 32'hDEADBEEF;
    #1;
    check_eq("mid_req1_ready", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    check_eq("mid_sw_before_rst", {31'd0, mem_sw}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_strb_after_rst", {29'd0, mem_sw, mem_sh, mem_sb}, 32'd0);
    check_eq("mid_mem_a", mem_a, 32'd0);
    check_eq("mid_mem_wd", mem_wd, 32'd0);
    check_eq("mid_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check_eq("mid_rsp1_data", rsp1_data, 32'd0);
    @(negedge clk); #1;
    check_eq("mid_ram_unchanged", ram[0], 32'hCAFEF00D);
    rst = 1'b0;

    // ---- contention: first tie after reset goes to port 0, then alternate ----
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 32'h10004;
    req1_valid = 1'b1; req1_we = 1'b0; req1_size = 2'b10; req1_addr = 32'h1000C;
    req1_wdata = 32'h0;
    for (int t = 0; t < 6; t++) begin
      exp_p = t % 2;
      #1;
      check_eq($sformatf("cont%0d_rdy0", t), {31'd0, req0_ready}, (exp_p == 0) ? 32'd1 : 32'd0);
      check_eq($sformatf("cont%0d_rdy1", t), {31'd0, req1_ready}, (exp_p == 1) ? 32'd1 : 32'd0);
      @(negedge clk); #1;
      check_eq($sformatf("cont%0d_mem_a", t), mem_a, (exp_p == 1) ? 32'h1000C : 32'h10004);
      @(negedge clk); #1;
      if (exp_p == 0) begin
        check_eq($sformatf("cont%0d_rsp0", t), rsp0_data, 32'h11223344);
        check_eq($sformatf("cont%0d_v0", t), {31'd0, rsp0_valid}, 32'd1);
      end else begin
        check_eq($sformatf("cont%0d_rsp1", t), rsp1_data, 32'h0BADC0DE);
        check_eq($sformatf("cont%0d_v1", t), {31'd0, rsp1_valid}, 32'd1);
      end
      check_eq($sformatf("cont%0d_other_rdy", t), {30'd0, req1_ready, req0_ready}, 32'd0);
      if (t == 5) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      @(negedge clk);
    end

    // ---- single read on port 0 ----
    run_txn(1'b0, 1'b0, 2'b00, 32'h10004, 32'h0, 3'b000, 32'h11223344, "rd0");

    // ---- store sizes: byte, half, word ----
    run_txn(1'b1, 1'b1, 2'b00, 32'h10008, 32'hAABBCCDD, 3'b001, 32'h0, "sb");
    check_eq("sb_ram", ram[2], 32'h000000DD);
    run_txn(1'b1, 1'b1, 2'b01, 32'h10008, 32'hAABBCCDD, 3'b010, 32'h0, "sh");
    check_eq("sh_ram", ram[2], 32'h0000CCDD);
    run_txn(1'b1, 1'b1, 2'b10, 32'h10008, 32'hAABBCCDD, 3'b100, 32'h0, "sw");
    check_eq("sw_ram", ram[2], 32'hAABBCCDD);

    // ---- backpressure on port 1 while port 0 waits ----
    rsp1_ready = 1'b0;
    @(negedge clk);
    req1_valid = 1'b1; req1_we = 1'b0; req1_size = 2'b10; req1_addr = 32'h10004;
    #1;
    check_eq("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 32'h10000;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq($sformatf("bp%0d_v1", c), {31'd0, rsp1_valid}, 32'd1);
      check_eq($sformatf("bp%0d_d1", c), rsp1_data, 32'h11223344);
      check_eq($sformatf("bp%0d_rdy0", c), {31'd0, req0_ready}, 32'd0);
      @(negedge clk);
    end
    rsp1_ready = 1'b1;
    @(negedge clk); #1;
    check_eq("bp_rsp1_clear", {31'd0, rsp1_valid}, 32'd0);
    check_eq("bp_req0_ready", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk); #1;
    check_eq("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check_eq("bp_rsp0_data", rsp0_data, 32'hCAFEF00D);
    @(negedge clk);

    // ---- store then load on port 1 ----
    run_txn(1'b1, 1'b1, 2'b10, 32'h1000C, 32'h55667788, 3'b100, 32'h0, "st");
    run_txn(1'b1, 1'b0, 2'b10, 32'h1000C, 32'h0, 3'b000, 32'h55667788, "ld");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the byte-addressed data RAM, whose write strobes are sb/sh/sw and whose read port is combinational and word-aligned. It shares the single RAM port between instruction fetch (port 0, read-only) and the load/store unit (port 1, read/write) using round-robin arbitration. Each transaction runs through an IDLE → ACCESS → RESP sequence. Requests and responses use valid/ready handshakes.

## Interface
- ADDRESS_LENGTH, 32, width of addresses and data words
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  port 0 read request
- req0_addr  in  ADDRESS_LENGTH  port 0 byte address
- req0_ready  out  1  port 0 request accepted this cycle
- rsp0_valid  out  1  port 0 read data valid
- rsp0_ready  in  1  port 0 consumes response
- rsp0_data  out  ADDRESS_LENGTH  port 0 read word
- req1_valid  in  1  port 1 request
- req1_we  in  1  1 = store, 0 = load
- req1_size  in  2  00 byte, 01 half, 10/11 word
- req1_addr  in  ADDRESS_LENGTH  port 1 byte address
- req1_wdata  in  ADDRESS_LENGTH  store data, LSB-aligned
- req1_ready  out  1  port 1 request accepted this cycle
- rsp1_valid  out  1  port 1 response valid (load data or store ack)
- rsp1_ready  in  1  port 1 consumes response
- rsp1_data  out  ADDRESS_LENGTH  load word; 0 for stores
- mem_a  out  ADDRESS_LENGTH  RAM address
- mem_wd  out  ADDRESS_LENGTH  RAM write data
- mem_sb, mem_sh, mem_sw  out  1 each  RAM byte/half/word write strobes
- mem_rd  in  ADDRESS_LENGTH  RAM read word (combinational from mem_a)

## Operation
- **State register:** IDLE, ACCESS, RESP. Reset value IDLE.
- **Grant register:** 1 bit, records the last granted port. Reset value 1, so port 0 wins the first tie.
- **Arbitration (IDLE only):**
  - If exactly one reqN_valid is high, that port is granted.
  - If both are high, the port not recorded as last grant is granted.
  - reqN_ready = (state==IDLE) && granted port==N && reqN_valid && !rst. This is combinational and never high outside IDLE.
- **Accept:** on an edge with valid && ready:
  - latch address into mem_a;
  - latch wdata into mem_wd (port 1 store only; otherwise 0);
  - latch we, size and port ID;
  - update the grant register;
  - move to ACCESS.
- **ACCESS (exactly one cycle):**
  - Port 1 store: exactly one strobe is high, per latched size (00 → mem_sb, 01 → mem_sh, 10/11 → mem_sw). The RAM commits at the end of this cycle.
  - Loads and port 0: all strobes low.
  - At the end of the cycle, capture mem_rd into the granted rspN_data (stores capture 0), then go to RESP.
- **RESP:**
  - rspN_valid is high for the granted port only. It and rspN_data stay stable until rspN_ready is high at a clock edge.
  - On that edge, clear rspN_valid and go to IDLE.
- **Alignment:** addresses and data pass through unmodified. Word alignment and sub-word extraction are the RAM's and the load unit's responsibility. No misalignment checks.
- **Outside ACCESS:** mem_sb/mem_sh/mem_sw are 0. mem_a and mem_wd hold their last latched values.
- **Reset (asynchronous, including mid-transaction):**
  - state → IDLE, grant register → 1.
  - All rsp*_valid, rsp*_data, mem_a, mem_wd and strobes → 0 immediately.
  - Any in-flight transaction is dropped. A store in ACCESS when rst rises is not committed.

## Timing
- Accept at edge E → ACCESS during cycle E..E+1 (store commits at E+1) → rsp valid from E+1.
- Minimum occupancy is 3 cycles per transaction: rsp_ready high at E+2 → IDLE, next accept at E+3 at the earliest.
- A late rsp_ready extends RESP. The other port waits and sees ready low.
- A request that arrives while the arbiter is not in IDLE waits. The requester holds valid, addr, we, size and wdata stable until ready.
- rspN_ready while rspN_valid is low is ignored.
- Starvation bound: while both ports hold valid continuously, grants strictly alternate.

## Test plan
- **Reset:** assert rst mid-ACCESS of a port 1 word store to 0x10000 (wdata 0xDEADBEEF) → strobes drop immediately, RAM at 0x10000 unchanged, all outputs 0, state IDLE, and the first tie after release goes to port 0.
- **Single read:** port 0 reads 0x10004 with RAM word 0x11223344 → req0_ready at E, mem_a=0x10004 in ACCESS, rsp0_valid=1 with rsp0_data=0x11223344 from E+1 to E+2.
- **Store sizes:** port 1 stores 0xAABBCCDD at 0x10008 with size 00, then 01, then 10 → exactly mem_sb, then mem_sh, then mem_sw high for one cycle each, and rsp1_data=0 for each.
- **Contention:** both ports hold valid for 6 transactions → grant order 0,1,0,1,0,1 with no gaps beyond 3 cycles each.
- **Backpressure:** hold rsp1_ready low for 5 cycles → rsp1_valid/rsp1_data stable throughout, req0_ready stays 0 despite req0_valid, and port 0 is accepted in the first IDLE cycle after release.
- **Store then load:** port 1 word store 0x55667788 to 0x1000C, then port 1 load of 0x1000C → rsp1_data=0x55667788.
